// File: rtl/shift_right_iterative_32_pkg.sv
// Shared definitions for the iterative right shifter.
// Holds the FSM state encoding, datapath widths and the set of legal
// per-cycle step sizes (kept here so a future left-shift variant can reuse them).
package shift_right_iterative_32_pkg;

  localparam int DATA_W       = 32;
  localparam int SHAMT_W      = 5;
  localparam int STEP_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Legal per-cycle step sizes are 1, 2, 4 and 8.
  function automatic bit step_is_legal(input int step);
    return (step == 1) || (step == 2) || (step == 4) || (step == 8);
  endfunction

endpackage

// File: rtl/shift_right_step.sv
// One combinational right-shift step.
// Ports:
//   work    in  32  word to shift
//   amt     in  5   shift amount for this step (0..STEP)
//   fill    in  1   value shifted into the vacated top bits
//   shifted out 32  work >> amt with the top amt bits equal to fill
module shift_right_step (
  input  logic [31:0] work,
  input  logic [4:0]  amt,
  input  logic        fill,
  output logic [31:0] shifted
);

  // Inverting around a logical shift turns the zero fill into a ones fill,
  // so a single shifter serves both fill values.
  always_comb begin
    if (fill) begin
      shifted = ~((~work) >> amt);
    end else begin
      shifted = work >> amt;
    end
  end

endmodule

// File: rtl/shift_right_iterative_32.sv
// Multi-cycle 32-bit right shifter (logical or arithmetic) for the ALU path.
// Shifts at most STEP bits per cycle under a start/done handshake.
// Ports:
//   clk_i    in  1   clock, rising edge
//   rst_i    in  1   asynchronous active-high reset
//   start_i  in  1   request, accepted only when idle
//   data_i   in  32  operand, sampled on accepted start
//   shamt_i  in  5   shift amount 0..31, sampled on accepted start
//   arith_i  in  1   1 = sign fill, 0 = zero fill, sampled on accepted start
//   busy_o   out 1   high while shifting and in the done cycle
//   done_o   out 1   one-cycle pulse, data_o valid from this cycle
//   data_o   out 32  last result, held until the next done_o
module shift_right_iterative_32
  import shift_right_iterative_32_pkg::*;
#(
  parameter int STEP = STEP_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  shamt_i,
  input  logic        arith_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] data_o
);

  // An illegal STEP falls back to the default rather than building a
  // shifter with an unsupported stride.
  localparam int         STEP_EFF = step_is_legal(STEP) ? STEP : STEP_DEFAULT;
  localparam logic [4:0] STEP_AMT = 5'(STEP_EFF);

  state_t      state;
  state_t      state_next;
  logic [31:0] work;
  logic [31:0] work_next;
  logic [31:0] shifted;
  logic [31:0] result;
  logic [4:0]  rem;
  logic [4:0]  rem_next;
  logic [4:0]  rem_after;
  logic [4:0]  amt;
  logic        sign;
  logic        sign_next;

  // amt never exceeds rem, so rem cannot underflow.
  assign amt       = (rem < STEP_AMT) ? rem : STEP_AMT;
  assign rem_after = rem - amt;

  shift_right_step u_step (
    .work    (work),
    .amt     (amt),
    .fill    (sign),
    .shifted (shifted)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_next = (shamt_i != 5'd0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        if (rem_after == 5'd0) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state != S_IDLE);
    done_o = (state == S_DONE);
  end

  // Operands are only captured in IDLE, so a start while busy cannot
  // disturb an operation in flight. The sign bit is frozen at capture.
  always_comb begin
    work_next = work;
    rem_next  = rem;
    sign_next = sign;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          work_next = data_i;
          rem_next  = shamt_i;
          sign_next = arith_i & data_i[31];
        end
      end
      S_SHIFT: begin
        work_next = shifted;
        rem_next  = rem_after;
      end
      default: begin
        work_next = work;
      end
    endcase
  end

  // The result register is loaded on the edge that enters DONE so that
  // data_o is already valid in the cycle done_o is high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      work   <= '0;
      rem    <= '0;
      sign   <= 1'b0;
      result <= '0;
    end else begin
      work <= work_next;
      rem  <= rem_next;
      sign <= sign_next;
      if ((state_next == S_DONE) && (state != S_DONE)) begin
        result <= work_next;
      end
    end
  end

  assign data_o = result;

endmodule

// File: tb/tb_shift_right_iterative_32.sv
// Self-checking bench for shift_right_iterative_32 with STEP = 4.
module tb_shift_right_iterative_32;

  localparam int TB_STEP = 4;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [31:0] data_i;
  logic [4:0]  shamt_i;
  logic        arith_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] data_o;

  int checks;
  int failures;

  shift_right_iterative_32 #(.STEP(TB_STEP)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .data_i  (data_i),
    .shamt_i (shamt_i),
    .arith_i (arith_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .data_o  (data_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference: plain shift operators on the whole word.
  function automatic logic [31:0] model_shift(input logic [31:0] d, input logic [4:0] s,
                                              input logic a);
    if (a) return 32'($signed(d) >>> s);
    return d >> s;
  endfunction

  // Reference latency: edges from the start edge (counted as 1) to done_o.
  function automatic int model_latency(input logic [4:0] s);
    return (int'(s) + TB_STEP - 1) / TB_STEP + 1;
  endfunction

  // Drives one request and observes it; no comparisons are made here.
  task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic a,
                        output int cycles, output logic [31:0] res,
                        output logic post_busy, output logic post_done,
                        output logic [31:0] post_data);
    @(negedge clk_i);
    start_i = 1'b1; data_i = d; shamt_i = s; arith_i = a;
    @(posedge clk_i); #1;
    start_i = 1'b0; data_i = $urandom; shamt_i = 5'($urandom); arith_i = 1'($urandom);
    cycles = -1;
    for (int n = 1; n <= 40; n++) begin
      if (done_o === 1'b1) begin
        cycles = n;
        break;
      end
      @(posedge clk_i); #1;
    end
    res = data_o;
    @(posedge clk_i); #1;
    post_busy = busy_o;
    post_done = done_o;
    post_data = data_o;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; data_i = '0; shamt_i = '0; arith_i = 1'b0;
    #2;
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
    checks++;
    if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done_o); end
    checks++;
    if (data_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_data: got %h expected 00000000", data_o); end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] vd [5] = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h12345678};
    logic [4:0]  vs [5] = '{5'd4, 5'd4, 5'd31, 5'd31, 5'd0};
    logic        va [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] ve [5] = '{32'h08000000, 32'hF8000000, 32'hFFFFFFFF, 32'h00000001, 32'h12345678};
    int          vl [5] = '{2, 2, 9, 9, 1};
    int cyc;
    logic [31:0] res, pdata;
    logic pbusy, pdone;
    for (int i = 0; i < 5; i++) begin
      run_op(vd[i], vs[i], va[i], cyc, res, pbusy, pdone, pdata);
      checks++;
      if (cyc !== vl[i]) begin failures++; $display("[TB] FAIL directed%0d_latency: got %0d expected %0d", i, cyc, vl[i]); end
      checks++;
      if (res !== ve[i]) begin failures++; $display("[TB] FAIL directed%0d_data: got %h expected %h", i, res, ve[i]); end
      checks++;
      if (pbusy !== 1'b0) begin failures++; $display("[TB] FAIL directed%0d_busy_after: got %b expected 0", i, pbusy); end
      checks++;
      if (pdone !== 1'b0) begin failures++; $display("[TB] FAIL directed%0d_done_pulse: got %b expected 0", i, pdone); end
      checks++;
      if (pdata !== ve[i]) begin failures++; $display("[TB] FAIL directed%0d_data_hold: got %h expected %h", i, pdata, ve[i]); end
    end
  endtask

  task automatic test_random();
    int cyc;
    logic [31:0] d, res, pdata, exp_d;
    logic [4:0] s;
    logic a, pbusy, pdone;
    for (int i = 0; i < 30; i++) begin
      d = $urandom; s = 5'($urandom); a = 1'($urandom);
      exp_d = model_shift(d, s, a);
      run_op(d, s, a, cyc, res, pbusy, pdone, pdata);
      checks++;
      if (cyc !== model_latency(s)) begin failures++; $display("[TB] FAIL random%0d_latency: got %0d expected %0d", i, cyc, model_latency(s)); end
      checks++;
      if (res !== exp_d) begin failures++; $display("[TB] FAIL random%0d_data: d=%h s=%0d a=%b got %h expected %h", i, d, s, a, res, exp_d); end
      checks++;
      if (pbusy !== 1'b0 || pdone !== 1'b0) begin failures++; $display("[TB] FAIL random%0d_idle_after: got busy=%b done=%b expected 0 0", i, pbusy, pdone); end
      checks++;
      if (pdata !== exp_d) begin failures++; $display("[TB] FAIL random%0d_data_hold: got %h expected %h", i, pdata, exp_d); end
    end
  endtask

  task automatic test_ignore_busy();
    int pulses = 0;
    int first = -1;
    logic [31:0] first_data = '0;
    @(negedge clk_i);
    start_i = 1'b1; data_i = 32'hA5A5A5A5; shamt_i = 5'd8; arith_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b1; data_i = 32'hFFFFFFFF; shamt_i = 5'd1; arith_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int n = 2; n <= 14; n++) begin
      if (n > 2) begin @(posedge clk_i); #1; end
      if (done_o === 1'b1) begin
        pulses++;
        if (first < 0) begin first = n; first_data = data_o; end
      end
    end
    checks++;
    if (pulses !== 1) begin failures++; $display("[TB] FAIL busy_start_pulses: got %0d expected 1", pulses); end
    checks++;
    if (first !== 3) begin failures++; $display("[TB] FAIL busy_start_latency: got %0d expected 3", first); end
    checks++;
    if (first_data !== 32'h00A5A5A5) begin failures++; $display("[TB] FAIL busy_start_data: got %h expected 00a5a5a5", first_data); end
  endtask

  task automatic test_back_to_back();
    int pulse_at[$];
    int exp_at [3] = '{3, 7, 11};
    @(negedge clk_i);
    start_i = 1'b1; data_i = 32'hA5A5A5A5; shamt_i = 5'd8; arith_i = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk_i); #1;
      if (done_o === 1'b1) pulse_at.push_back(n);
    end
    start_i = 1'b0;
    checks++;
    if (pulse_at.size() !== 3) begin failures++; $display("[TB] FAIL b2b_pulse_count: got %0d expected 3", pulse_at.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= pulse_at.size()) begin
        failures++; $display("[TB] FAIL b2b_pulse%0d_cycle: got none expected %0d", i, exp_at[i]);
      end else if (pulse_at[i] !== exp_at[i]) begin
        failures++; $display("[TB] FAIL b2b_pulse%0d_cycle: got %0d expected %0d", i, pulse_at[i], exp_at[i]);
      end
    end
    checks++;
    if (data_o !== 32'h00A5A5A5) begin failures++; $display("[TB] FAIL b2b_data: got %h expected 00a5a5a5", data_o); end
    repeat (4) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset_mid_shift();
    int pulses = 0;
    int cyc;
    logic [31:0] res, pdata;
    logic pbusy, pdone;
    @(negedge clk_i);
    start_i = 1'b1; data_i = 32'h80000000; shamt_i = 5'd31; arith_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy_o); end
    checks++;
    if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL midrst_done: got %b expected 0", done_o); end
    checks++;
    if (data_o !== 32'h0) begin failures++; $display("[TB] FAIL midrst_data: got %h expected 00000000", data_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk_i); #1;
      if (done_o === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin failures++; $display("[TB] FAIL midrst_no_done: got %0d pulses expected 0", pulses); end
    run_op(32'hF0000000, 5'd5, 1'b1, cyc, res, pbusy, pdone, pdata);
    checks++;
    if (cyc !== 3) begin failures++; $display("[TB] FAIL midrst_next_latency: got %0d expected 3", cyc); end
    checks++;
    if (res !== 32'hFF800000) begin failures++; $display("[TB] FAIL midrst_next_data: got %h expected ff800000", res); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
